gfx_op_scheduler: RTL and testbench

GFX_OP_SCHEDULER -- requirements
Module: gfx_op_scheduler

---
 rtl/gfx_op_scheduler_pkg.sv | 23 ++
 rtl/gfx_op_scheduler_if.sv | 15 +
 rtl/gfx_cmd_fifo.sv | 39 +++
 rtl/gfx_op_scheduler.sv | 79 +++++++
 tb/tb_gfx_op_scheduler.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/gfx_op_scheduler_pkg.sv
// gfx_op_scheduler_pkg: shared FSM states, op encoding, screen limits and command record
package gfx_op_scheduler_pkg;
  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, SETTLE, WAIT_DONE} state_t;
  localparam logic OP_FILL = 1'b0;
  localparam logic OP_BLIT = 1'b1;
  localparam logic [8:0] MAX_X = 9'd319;
  localparam logic [7:0] MAX_Y = 8'd239;
  typedef struct packed {
    logic       op;
    logic       fill_value;
    logic [8:0] x1;
    logic [7:0] y1;
    logic [8:0] x2;
    logic [7:0] y2;
    logic [8:0] width;
    logic [7:0] height;
  } cmd_t;
  localparam int CMD_W = $bits(cmd_t);
  function automatic logic cmd_invalid(input cmd_t c);
    return c.x1 > c.x2 || c.y1 > c.y2 || c.x2 > MAX_X || c.y2 > MAX_Y ||
           (c.op == OP_BLIT && (c.width == '0 || c.height == '0));
  endfunction
endpackage

// File: rtl/gfx_op_scheduler_if.sv
// gfx_op_scheduler_if: command push bus (valid/ready + op, fill value, corners, blit extent)
interface gfx_op_scheduler_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_op;
  logic       cmd_fill_value;
  logic [8:0] cmd_x1;
  logic [8:0] cmd_x2;
  logic [7:0] cmd_y1;
  logic [7:0] cmd_y2;
  logic [8:0] cmd_width;
  logic [7:0] cmd_height;
  modport master (output cmd_valid, cmd_op, cmd_fill_value, cmd_x1, cmd_x2, cmd_y1, cmd_y2, cmd_width, cmd_height, input cmd_ready);
  modport slave (input cmd_valid, cmd_op, cmd_fill_value, cmd_x1, cmd_x2, cmd_y1, cmd_y2, cmd_width, cmd_height, output cmd_ready);
endinterface

// File: rtl/gfx_cmd_fifo.sv
// gfx_cmd_fifo: DEPTH x W command FIFO; ports clk/reset_n, push/pop, din/dout, level, full/empty
module gfx_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] level_q;
  logic do_push, do_pop;
  assign full = level_q == (AW+1)'(DEPTH);
  assign empty = level_q == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem_q[rd_q];
  assign level = level_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/gfx_op_scheduler.sv
// gfx_op_scheduler: queues fill/blit commands, validates them and issues start pulses to the engine
module gfx_op_scheduler
  import gfx_op_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  gfx_op_scheduler_if.slave       cmd,
  input  logic                    gc_busy,
  input  logic                    gc_error,
  input  logic                    clear_error,
  output logic [8:0]              X1,
  output logic [8:0]              X2,
  output logic [7:0]              Y1,
  output logic [7:0]              Y2,
  output logic                    fill_value,
  output logic [8:0]              blit_x_width,
  output logic [7:0]              blit_y_height,
  output logic                    start_fill,
  output logic                    start_blit,
  output logic                    error,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    idle
);
  state_t state_q, state_d;
  cmd_t cmd_q, cmd_d, head, din;
  logic error_q, error_d, pop, full, empty;
  assign din = '{cmd.cmd_op, cmd.cmd_fill_value, cmd.cmd_x1, cmd.cmd_y1, cmd.cmd_x2, cmd.cmd_y2, cmd.cmd_width, cmd.cmd_height};
  assign cmd.cmd_ready = !full;
  assign pop = state_q == IDLE && !empty && !gc_busy;
  gfx_cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(cmd.cmd_valid),
    .pop(pop),
    .din(din),
    .dout(head),
    .level(level),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cmd_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      error_q <= error_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = pop ? CHECK : IDLE;
      CHECK:     state_d = cmd_invalid(cmd_q) ? IDLE : ISSUE;
      ISSUE:     state_d = SETTLE;
      SETTLE:    state_d = WAIT_DONE;
      WAIT_DONE: state_d = gc_busy ? WAIT_DONE : IDLE;
      default:   state_d = IDLE;
    endcase
  end
  always_comb begin
    cmd_d = pop ? head : cmd_q;
    error_d = gc_error || (state_q == CHECK && cmd_invalid(cmd_q)) || (error_q && !clear_error);
    start_fill = state_q == ISSUE && cmd_q.op == OP_FILL;
    start_blit = state_q == ISSUE && cmd_q.op == OP_BLIT;
    X1 = cmd_q.x1;
    X2 = cmd_q.x2;
    Y1 = cmd_q.y1;
    Y2 = cmd_q.y2;
    fill_value = cmd_q.fill_value;
    blit_x_width = cmd_q.width;
    blit_y_height = cmd_q.height;
    error = error_q;
    idle = empty && state_q == IDLE;
  end
endmodule

// File: tb/tb_gfx_op_scheduler.sv
// tb_gfx_op_scheduler: directed and randomized checks of gfx_op_scheduler against a command-queue model
module tb_gfx_op_scheduler;
  import gfx_op_scheduler_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 0, reset_n = 0;
  logic gc_error = 0, clear_error = 0, auto_eng = 0, man_busy = 0, eng_busy = 0, gc_busy;
  logic [8:0] X1, X2, bw;
  logic [7:0] Y1, Y2, bh;
  logic fill_value, start_fill, start_blit, error, idle;
  logic [2:0] level;
  cmd_t obs_q[$], exp_q[$];
  int both_cnt = 0, eng_cnt = 0, n_pass = 0, n_tot = 0;
  always #5 clk = ~clk;
  assign gc_busy = auto_eng ? eng_busy : man_busy;
  gfx_op_scheduler_if ci();
  gfx_op_scheduler #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .cmd(ci), .gc_busy(gc_busy), .gc_error(gc_error),
    .clear_error(clear_error), .X1(X1), .X2(X2), .Y1(Y1), .Y2(Y2), .fill_value(fill_value),
    .blit_x_width(bw), .blit_y_height(bh), .start_fill(start_fill), .start_blit(start_blit),
    .error(error), .level(level), .idle(idle)
  );
  always @(negedge clk) begin
    if (start_fill || start_blit) begin
      obs_q.push_back(cmd_t'{start_blit, fill_value, X1, Y1, X2, Y2, bw, bh});
      if (start_fill && start_blit) both_cnt++;
      eng_cnt = int'($urandom_range(0, 3));
    end else if (eng_cnt > 0) eng_cnt--;
    eng_busy = eng_cnt > 0;
  end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  function automatic cmd_t mk(input logic op, input logic fv, input int x1, input int y1, input int x2, input int y2, input int w, input int h);
    return '{op, fv, 9'(x1), 8'(y1), 9'(x2), 8'(y2), 9'(w), 8'(h)};
  endfunction
  function automatic logic bad(input cmd_t c);
    return int'(c.x1) > int'(c.x2) || int'(c.y1) > int'(c.y2) || int'(c.x2) > 319 || int'(c.y2) > 239 ||
           (c.op && (c.width == 0 || c.height == 0));
  endfunction
  function automatic cmd_t rnd();
    cmd_t c;
    int k = int'($urandom_range(0, 7));
    c.op = 1'($urandom_range(0, 1));
    c.fill_value = 1'($urandom_range(0, 1));
    c.x1 = 9'($urandom_range(0, 300));
    c.x2 = 9'($urandom_range(c.x1, 319));
    c.y1 = 8'($urandom_range(0, 230));
    c.y2 = 8'($urandom_range(c.y1, 239));
    c.width = 9'($urandom_range(1, 320));
    c.height = 8'($urandom_range(1, 240));
    if (k == 0) c.x1 = 9'(c.x2 + 1);
    if (k == 1) c.y2 = 8'($urandom_range(240, 255));
    if (k == 2) c.width = 0;
    return c;
  endfunction
  task automatic set_cmd(input cmd_t c);
    ci.cmd_valid = 1;
    ci.cmd_op = c.op;
    ci.cmd_fill_value = c.fill_value;
    ci.cmd_x1 = c.x1;
    ci.cmd_y1 = c.y1;
    ci.cmd_x2 = c.x2;
    ci.cmd_y2 = c.y2;
    ci.cmd_width = c.width;
    ci.cmd_height = c.height;
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push(input cmd_t c);
    int n = 0;
    set_cmd(c);
    while (!ci.cmd_ready && n < 300) begin
      cyc(1);
      n++;
    end
    check("push_ready", ci.cmd_ready, 1);
    @(posedge clk);
    #1 ci.cmd_valid = 0;
  endtask
  task automatic wait_obs(input int want);
    int n = 0;
    while (obs_q.size() < want && n < 300) begin
      cyc(1);
      n++;
    end
    check("start_count", obs_q.size(), want);
  endtask
  task automatic wait_idle();
    int n = 0;
    while (!idle && n < 300) begin
      cyc(1);
      n++;
    end
    check("idle", idle, 1);
  endtask
  initial begin
    int base;
    logic any_bad;
    cmd_t c;
    set_cmd('0);
    ci.cmd_valid = 0;
    cyc(3);
    check("rst_level", level, 0);
    check("rst_ready", ci.cmd_ready, 1);
    check("rst_idle", idle, 1);
    check("rst_error", error, 0);
    check("rst_starts", {start_fill, start_blit}, 0);
    check("rst_x1", X1, 0);
    @(negedge clk) reset_n = 1;
    #1 check("release_ready", ci.cmd_ready, 1);
    cyc(1);
    base = obs_q.size();
    push(mk(0, 1, 10, 20, 50, 60, 0, 0));
    @(negedge clk) check("lat_c1", start_fill, 0);
    @(negedge clk) check("lat_c2", start_fill, 0);
    @(negedge clk) check("lat_c3", start_fill, 1);
    check("lat_blit", start_blit, 0);
    man_busy = 1;
    check("fill_x1", X1, 10);
    check("fill_y2", Y2, 60);
    check("fill_val", fill_value, 1);
    cyc(4);
    check("fill_busy_idle", idle, 0);
    check("fill_hold_x1", X1, 10);
    man_busy = 0;
    cyc(3);
    check("fill_done_idle", idle, 1);
    check("fill_one_pulse", obs_q.size(), base + 1);
    man_busy = 1;
    base = obs_q.size();
    for (int i = 0; i < 4; i++) push(mk(0, 0, i + 1, 0, 100, 100, 0, 0));
    check("bp_level", level, 4);
    check("bp_ready", ci.cmd_ready, 0);
    set_cmd(mk(0, 0, 5, 0, 100, 100, 0, 0));
    cyc(3);
    check("bp_level_held", level, 4);
    check("bp_no_start", obs_q.size(), base);
    man_busy = 0;
    push(mk(0, 0, 5, 0, 100, 100, 0, 0));
    wait_obs(base + 5);
    wait_idle();
    if (obs_q.size() >= base + 5)
      for (int i = 0; i < 5; i++) check("bp_order", obs_q[base + i].x1, 64'(i + 1));
    base = obs_q.size();
    push(mk(0, 0, 100, 0, 50, 10, 0, 0));
    cyc(8);
    check("inv_no_start", obs_q.size(), base);
    check("inv_error", error, 1);
    push(mk(0, 1, 7, 1, 8, 2, 0, 0));
    wait_obs(base + 1);
    if (obs_q.size() > base) check("inv_next_x1", obs_q[base].x1, 7);
    wait_idle();
    check("inv_error_held", error, 1);
    clear_error = 1;
    cyc(1);
    clear_error = 0;
    check("inv_cleared", error, 0);
    base = obs_q.size();
    push(mk(1, 0, 0, 0, 10, 10, 0, 5));
    cyc(8);
    check("blit_w0_no_start", obs_q.size(), base);
    check("blit_w0_error", error, 1);
    clear_error = 1;
    cyc(1);
    clear_error = 0;
    push(mk(1, 0, 0, 0, 319, 239, 8, 8));
    wait_obs(base + 1);
    wait_idle();
    check("blit_one_pulse", obs_q.size(), base + 1);
    if (obs_q.size() > base) begin
      check("blit_op", obs_q[base].op, 1);
      check("blit_width", obs_q[base].width, 8);
      check("blit_x2", obs_q[base].x2, 319);
      check("blit_y2", obs_q[base].y2, 239);
    end
    check("blit_no_error", error, 0);
    base = obs_q.size();
    push(mk(0, 0, 1, 1, 2, 2, 0, 0));
    wait_obs(base + 1);
    man_busy = 1;
    for (int i = 0; i < 3; i++) push(mk(1, 1, 3, 3, 9, 9, 4, 4));
    check("rst_mid_level", level, 3);
    @(negedge clk) reset_n = 0;
    #1 check("rst_mid_level0", level, 0);
    check("rst_mid_x1", X1, 0);
    check("rst_mid_starts", {start_fill, start_blit}, 0);
    @(negedge clk) reset_n = 1;
    man_busy = 0;
    #1 check("rst_mid_ready", ci.cmd_ready, 1);
    cyc(15);
    check("rst_mid_no_start", obs_q.size(), base + 1);
    check("rst_mid_idle", idle, 1);
    @(negedge clk) begin
      gc_error = 1;
      clear_error = 1;
    end
    cyc(1);
    gc_error = 0;
    clear_error = 0;
    check("set_wins", error, 1);
    clear_error = 1;
    cyc(1);
    clear_error = 0;
    check("clear_after", error, 0);
    auto_eng = 1;
    base = obs_q.size();
    any_bad = 0;
    for (int i = 0; i < 40; i++) begin
      c = rnd();
      if (bad(c)) any_bad = 1;
      else exp_q.push_back(c);
      push(c);
      check("rnd_ready_level", ci.cmd_ready, level != 3'(DEPTH));
      cyc(int'($urandom_range(0, 3)));
    end
    begin
      int n = 0;
      while (!(idle && obs_q.size() >= base + exp_q.size()) && n < 3000) begin
        cyc(1);
        n++;
      end
    end
    cyc(10);
    check("rnd_count", obs_q.size(), base + exp_q.size());
    if (obs_q.size() == base + exp_q.size())
      foreach (exp_q[i]) check("rnd_cmd", obs_q[base + i], exp_q[i]);
    check("rnd_error", error, any_bad);
    check("exclusive_starts", both_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
